// File: rtl/arm_register_file_if.sv
// Writeback, PC-update and read-port signals between the pipeline and the ARM register file.
// Valid/ready is not used: every input is sampled on each rising edge and the driver holds it stable across it.
interface arm_register_file_if;
    logic        RW;
    logic [3:0]  RD;
    logic [31:0] PW;
    logic [3:0]  RA;
    logic [3:0]  RB;
    logic [3:0]  RC;
    logic        PC_Ld;
    logic [31:0] PC_in;
    logic [31:0] PA;
    logic [31:0] PB;
    logic [31:0] PD;
    logic [31:0] PC_out;

    modport master (
        output RW, RD, PW, RA, RB, RC, PC_Ld, PC_in,
        input  PA, PB, PD, PC_out
    );

    modport slave (
        input  RW, RD, PW, RA, RB, RC, PC_Ld, PC_in,
        output PA, PB, PD, PC_out
    );
endinterface

// File: rtl/arm_register_file.sv
// Sixteen 32-bit architectural registers with R15 as PC: three combinational read ports,
// one writeback port and a dedicated PC load path. No write-to-read bypass.
module arm_register_file #(
    parameter logic [31:0] PC_RESET       = 32'd0,
    parameter logic [31:0] PC_READ_OFFSET = 32'd8
) (
    input logic               Clk,
    input logic               Reset,
    arm_register_file_if.slave rf
);
    logic [31:0] regs_q [0:15];
    logic [31:0] regs_d [0:15];

    // PC load first, then the writeback port, so RW to R15 overrides PC_Ld.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (rf.PC_Ld) begin
            regs_d[15] = rf.PC_in;
        end
        if (rf.RW) begin
            regs_d[rf.RD] = rf.PW;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= 32'd0;
            end
            regs_q[15] <= PC_RESET;
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads of R15 see the pipelined PC+8 value; the sum wraps silently.
    function automatic logic [31:0] read_port(input logic [3:0] addr);
        if (addr == 4'd15) begin
            return regs_q[15] + PC_READ_OFFSET;
        end
        return regs_q[addr];
    endfunction

    assign rf.PA     = read_port(rf.RA);
    assign rf.PB     = read_port(rf.RB);
    assign rf.PD     = read_port(rf.RC);
    assign rf.PC_out = regs_q[15];
endmodule

// File: tb/tb_arm_register_file.sv
// Bench for arm_register_file: directed vector table, reset corner sequences and
// randomized traffic against an array model of the sixteen registers.
module tb_arm_register_file;
    logic Clk;
    logic Reset;
    logic clk_en;

    arm_register_file_if rf ();

    arm_register_file dut (
        .Clk  (Clk),
        .Reset(Reset),
        .rf   (rf)
    );

    // Gated clock so the reset check can run with no edges at all.
    initial Clk = 1'b0;
    always begin
        #5;
        if (clk_en) Clk = ~Clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        rw;
        logic [3:0]  rd;
        logic [31:0] pw;
        logic        pcld;
        logic [31:0] pcin;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [31:0] exp_pa;
        logic [31:0] exp_pb;
        logic [31:0] exp_pd;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [0:8];

    logic [31:0] mdl [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [3:0] rd, input logic [31:0] pw,
                         input logic pcld, input logic [31:0] pcin,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
        rf.RW    = rw;
        rf.RD    = rd;
        rf.PW    = pw;
        rf.PC_Ld = pcld;
        rf.PC_in = pcin;
        rf.RA    = ra;
        rf.RB    = rb;
        rf.RC    = rc;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] mdl_read(input logic [3:0] a);
        return (a == 4'd15) ? mdl[15] + 32'd8 : mdl[a];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    endtask

    initial begin
        vecs[0] = '{rw:1, rd:5,  pw:32'hDEADBEEF, pcld:0, pcin:32'h0,  ra:5,  rb:15, rc:0,
                    exp_pa:32'hDEADBEEF, exp_pb:32'h8, exp_pd:32'h0, exp_pc:32'h0};
        vecs[1] = '{rw:0, rd:0,  pw:32'h0,        pcld:1, pcin:32'h4,  ra:15, rb:5,  rc:3,
                    exp_pa:32'hC, exp_pb:32'hDEADBEEF, exp_pd:32'h0, exp_pc:32'h4};
        vecs[2] = '{rw:0, rd:0,  pw:32'h0,        pcld:1, pcin:32'h8,  ra:15, rb:15, rc:15,
                    exp_pa:32'h10, exp_pb:32'h10, exp_pd:32'h10, exp_pc:32'h8};
        vecs[3] = '{rw:0, rd:0,  pw:32'h0,        pcld:1, pcin:32'hC,  ra:0,  rb:5,  rc:15,
                    exp_pa:32'h0, exp_pb:32'hDEADBEEF, exp_pd:32'h14, exp_pc:32'hC};
        vecs[4] = '{rw:1, rd:15, pw:32'h100,      pcld:1, pcin:32'h4,  ra:15, rb:2,  rc:5,
                    exp_pa:32'h108, exp_pb:32'h0, exp_pd:32'hDEADBEEF, exp_pc:32'h100};
        vecs[5] = '{rw:1, rd:2,  pw:32'h100,      pcld:1, pcin:32'h4,  ra:2,  rb:15, rc:2,
                    exp_pa:32'h100, exp_pb:32'hC, exp_pd:32'h100, exp_pc:32'h4};
        vecs[6] = '{rw:1, rd:15, pw:32'hFFFFFFFC, pcld:0, pcin:32'h0,  ra:15, rb:2,  rc:15,
                    exp_pa:32'h4, exp_pb:32'h100, exp_pd:32'h4, exp_pc:32'hFFFFFFFC};
        vecs[7] = '{rw:1, rd:0,  pw:32'h12345678, pcld:0, pcin:32'h0,  ra:0,  rb:0,  rc:0,
                    exp_pa:32'h12345678, exp_pb:32'h12345678, exp_pd:32'h12345678, exp_pc:32'hFFFFFFFC};
        vecs[8] = '{rw:0, rd:0,  pw:32'hFFFFFFFF, pcld:0, pcin:32'h80, ra:0,  rb:15, rc:5,
                    exp_pa:32'h12345678, exp_pb:32'h4, exp_pd:32'hDEADBEEF, exp_pc:32'hFFFFFFFC};

        clk_en = 1'b0;
        Reset  = 1'b0;
        drive(0, 0, 0, 0, 0, 3, 15, 0);

        // Reset with the clock stopped.
        #2 Reset = 1'b1;
        #3;
        check("reset_pc_out", rf.PC_out, 32'h0);
        check("reset_pa_r3", rf.PA, 32'h0);
        check("reset_pb_r15", rf.PB, 32'h8);
        Reset = 1'b0;
        #2;
        check("after_reset_pc_out", rf.PC_out, 32'h0);

        // Pending write must not be visible before its edge.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 15, 0);
        #1;
        check("no_bypass_pa_r5", rf.PA, 32'h0);

        clk_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rw, vecs[i].rd, vecs[i].pw, vecs[i].pcld, vecs[i].pcin,
                  vecs[i].ra, vecs[i].rb, vecs[i].rc);
            tick();
            check($sformatf("vec%0d_pa", i), rf.PA, vecs[i].exp_pa);
            check($sformatf("vec%0d_pb", i), rf.PB, vecs[i].exp_pb);
            check($sformatf("vec%0d_pd", i), rf.PD, vecs[i].exp_pd);
            check($sformatf("vec%0d_pc", i), rf.PC_out, vecs[i].exp_pc);
        end

        // Reset arriving mid-cycle over a pending write.
        drive(1, 7, 32'h55, 1, 32'h40, 7, 15, 7);
        tick();
        check("mid_setup_r7", rf.PA, 32'h55);
        check("mid_setup_pc", rf.PC_out, 32'h40);
        drive(1, 7, 32'hAA, 0, 32'h0, 7, 15, 7);
        #2 Reset = 1'b1;
        #1;
        check("mid_reset_r7", rf.PA, 32'h0);
        check("mid_reset_pc", rf.PC_out, 32'h0);
        check("mid_reset_pb_r15", rf.PB, 32'h8);
        tick();
        check("held_reset_r7", rf.PA, 32'h0);
        Reset = 1'b0;
        tick();
        check("post_reset_r7", rf.PA, 32'hAA);
        check("post_reset_pc", rf.PC_out, 32'h0);

        // Randomized traffic against the array model.
        @(negedge Clk);
        Reset = 1'b1;
        #1 Reset = 1'b0;
        mdl_reset();
        for (int n = 0; n < 300; n++) begin
            logic        rw, pcld;
            logic [3:0]  rd, ra, rb, rc;
            logic [31:0] pw, pcin;
            rw   = ($urandom_range(0, 3) != 0);
            pcld = $urandom_range(0, 1);
            rd   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            pw   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
            pcin = $urandom;
            ra   = ($urandom_range(0, 2) == 0) ? rd : 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rc   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            drive(rw, rd, pw, pcld, pcin, ra, rb, rc);
            #1;
            check("rnd_pre_pa", rf.PA, mdl_read(ra));
            @(posedge Clk);
            #1;
            if (pcld) mdl[15] = pcin;
            if (rw) mdl[rd] = pw;
            check("rnd_pa", rf.PA, mdl_read(ra));
            check("rnd_pb", rf.PB, mdl_read(rb));
            check("rnd_pd", rf.PD, mdl_read(rc));
            check("rnd_pc", rf.PC_out, mdl[15]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
